// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing generator (counters, phase FSMs, registered syncs)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last count of each phase; the FSM leaves the phase on that count.
    localparam logic [9:0] c_H_ACT_END = 10'(H_ACTIVE - 1);
    localparam logic [9:0] c_H_FP_END  = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] c_H_SYN_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_H_END     = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_ACT_END = 10'(V_ACTIVE - 1);
    localparam logic [9:0] c_V_FP_END  = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] c_V_SYN_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] c_V_END     = 10'(V_TOTAL - 1);

    localparam logic [1:0] c_H_ACT = 2'd0;
    localparam logic [1:0] c_H_FPS = 2'd1;
    localparam logic [1:0] c_H_SYN = 2'd2;
    localparam logic [1:0] c_H_BPS = 2'd3;
    localparam logic [1:0] c_V_ACT = 2'd0;
    localparam logic [1:0] c_V_FPS = 2'd1;
    localparam logic [1:0] c_V_SYN = 2'd2;
    localparam logic [1:0] c_V_BPS = 2'd3;

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [1:0] r_h_state;
    logic [1:0] r_v_state;

    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_line_start;
    logic       r_frame_start;

    logic w_h_wrap;
    logic w_v_wrap;

    assign w_h_wrap = (r_h_cnt == c_H_END);
    assign w_v_wrap = (r_v_cnt == c_V_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_h_state <= c_H_ACT;
            r_v_state <= c_V_ACT;
        end else if (en) begin
            r_h_cnt <= w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;

            case (r_h_state)
                c_H_ACT: if (r_h_cnt == c_H_ACT_END) r_h_state <= c_H_FPS;
                c_H_FPS: if (r_h_cnt == c_H_FP_END)  r_h_state <= c_H_SYN;
                c_H_SYN: if (r_h_cnt == c_H_SYN_END) r_h_state <= c_H_BPS;
                default: if (w_h_wrap)               r_h_state <= c_H_ACT;
            endcase

            // Vertical counter and phase only advance on the line wrap.
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
                case (r_v_state)
                    c_V_ACT: if (r_v_cnt == c_V_ACT_END) r_v_state <= c_V_FPS;
                    c_V_FPS: if (r_v_cnt == c_V_FP_END)  r_v_state <= c_V_SYN;
                    c_V_SYN: if (r_v_cnt == c_V_SYN_END) r_v_state <= c_V_BPS;
                    default: if (w_v_wrap)               r_v_state <= c_V_ACT;
                endcase
            end
        end
    end

    // Output stage: one-cycle registered view of the counters and phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_hsync       <= (r_h_state == c_H_SYN) ? HS_POL : ~HS_POL;
            r_vsync       <= (r_v_state == c_V_SYN) ? VS_POL : ~VS_POL;
            r_de          <= (r_h_state == c_H_ACT) && (r_v_state == c_V_ACT);
            r_x           <= r_h_cnt;
            r_y           <= r_v_cnt;
            r_line_start  <= (r_h_cnt == 10'd0);
            r_frame_start <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for vga_timing_gen (default and reduced timings)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic       c_hs, c_vs, c_de, c_ls, c_fs;
    logic [9:0] c_x, c_y;

    vga_timing_gen u_dut_a (
        .clk(clk), .rst(rst), .en(en),
        .hsync(a_hs), .vsync(a_vs), .de(a_de), .x(a_x), .y(a_y),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
        .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_c (
        .clk(clk), .rst(rst), .en(en),
        .hsync(c_hs), .vsync(c_vs), .de(c_de), .x(c_x), .y(c_y),
        .line_start(c_ls), .frame_start(c_fs)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t last_a, last_b, last_c;

    // Raster position the DUT counters hold at the next edge.
    int da_h = 0, da_v = 0;
    int sm_h = 0, sm_v = 0;

    bit chk_period = 1'b0;
    int last_fs = -1;
    int last_ls = -1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic exp_t model(input int h, input int v,
                                   input int ha, input int hf, input int hsn, input int hb,
                                   input int va, input int vf, input int vsn, input int vb,
                                   input logic hp, input logic vp);
        exp_t e;
        e.de = (h < ha) && (v < va);
        e.hs = (h >= ha + hf && h < ha + hf + hsn) ? hp : ~hp;
        e.vs = (v >= va + vf && v < va + vf + vsn) ? vp : ~vp;
        e.x  = 10'(h);
        e.y  = 10'(v);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic exp_t rst_val(input logic hp, input logic vp);
        exp_t e;
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        return e;
    endfunction

    task automatic advance(inout int h, inout int v, input int htot, input int vtot);
        if (h == htot - 1) begin
            h = 0;
            v = (v == vtot - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    task automatic tick(input logic r, input logic e);
        exp_t ea, eb, ec;
        @(negedge clk);
        rst = r;
        en  = e;
        if (r) begin
            ea = rst_val(1'b0, 1'b0);
            eb = rst_val(1'b0, 1'b0);
            ec = rst_val(1'b1, 1'b1);
            da_h = 0; da_v = 0; sm_h = 0; sm_v = 0;
        end else if (e) begin
            ea = model(da_h, da_v, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
            eb = model(sm_h, sm_v, 16, 4, 6, 4, 8, 2, 2, 3, 1'b0, 1'b0);
            ec = model(sm_h, sm_v, 16, 4, 6, 4, 8, 2, 2, 3, 1'b1, 1'b1);
            advance(da_h, da_v, 800, 525);
            advance(sm_h, sm_v, 30, 15);
        end else begin
            ea = last_a; ea.ls = 1'b0; ea.fs = 1'b0;
            eb = last_b; eb.ls = 1'b0; eb.fs = 1'b0;
            ec = last_c; ec.ls = 1'b0; ec.fs = 1'b0;
        end
        last_a = ea; last_b = eb; last_c = ec;
        q_a.push_back(ea);
        q_b.push_back(eb);
        q_c.push_back(ec);

        @(posedge clk);
        #1;
        cyc++;
        check_val("dut_a", 32'({a_de, a_hs, a_vs, a_x, a_y, a_ls, a_fs}), 32'(q_a.pop_front()));
        check_val("dut_b", 32'({b_de, b_hs, b_vs, b_x, b_y, b_ls, b_fs}), 32'(q_b.pop_front()));
        check_val("dut_c", 32'({c_de, c_hs, c_vs, c_x, c_y, c_ls, c_fs}), 32'(q_c.pop_front()));

        if (chk_period) begin
            if (b_fs) begin
                if (last_fs >= 0) check_val("fs_period", 32'(cyc - last_fs), 32'd450);
                last_fs = cyc;
            end
            if (b_ls) begin
                if (last_ls >= 0) check_val("ls_period", 32'(cyc - last_ls), 32'd30);
                last_ls = cyc;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);

        // Two reduced frames plus one full default line, with period tracking.
        chk_period = 1'b1;
        for (int i = 0; i < 910; i++) tick(1'b0, 1'b1);
        chk_period = 1'b0;

        // Freeze mid-line, mid-frame, then resume.
        for (int i = 0; i < 500 && !(sm_h == 10 && sm_v == 5); i++) tick(1'b0, 1'b1);
        check_val("freeze_x", 32'(b_x), 32'd9);
        check_val("freeze_y", 32'(b_y), 32'd5);
        for (int i = 0; i < 37; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);

        // Reset while vsync is asserted; rst wins over en.
        for (int i = 0; i < 500 && !(sm_h == 20 && sm_v == 11); i++) tick(1'b0, 1'b1);
        check_val("vs_asserted", 32'(b_vs), 32'd0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        check_val("fs_after_rst", 32'(b_fs), 32'd1);
        for (int i = 0; i < 500; i++) tick(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixel clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixel clocks.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixel clocks.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter HS_POL, default 0, asserted level of hsync (0 = active low).
REQ-010 Parameter VS_POL, default 0, asserted level of vsync (0 = active low).
REQ-011 clk  input  1  pixel clock (25 MHz PLL secondary output); sole clock.
REQ-012 rst  input  1  synchronous, active-high reset.
REQ-013 en  input  1  count enable; tied to PLL locked; low freezes the block.
REQ-014 hsync  output  1  horizontal sync, polarity per HS_POL.
REQ-015 vsync  output  1  vertical sync, polarity per VS_POL.
REQ-016 de  output  1  data enable, high only for visible pixels.
REQ-017 x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-018 y  output  10  current line count, 0..V_TOTAL-1.
REQ-019 line_start  output  1  one-cycle pulse on first clock of each line.
REQ-020 frame_start  output  1  one-cycle pulse on first clock of each frame.

Function
REQ-021 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525); both SHALL be at most 1024.
REQ-022 Internal h_cnt SHALL increment by 1 each clk with en=1 and wrap from H_TOTAL-1 to 0.
REQ-023 Internal v_cnt SHALL increment only on the h_cnt wrap cycle and wrap from V_TOTAL-1 to 0 on the same cycle that h_cnt wraps.
REQ-024 Horizontal phase FSM SHALL have states H_ACT, H_FPS, H_SYN, H_BPS: H_ACT->H_FPS at h_cnt=H_ACTIVE-1, H_FPS->H_SYN at H_ACTIVE+H_FP-1, H_SYN->H_BPS at H_ACTIVE+H_FP+H_SYNC-1, H_BPS->H_ACT at H_TOTAL-1.
REQ-025 Vertical phase FSM SHALL have states V_ACT, V_FPS, V_SYN, V_BPS with analogous transitions on v_cnt boundaries, taken only on h_cnt wrap cycles.
REQ-026 All outputs SHALL be registered and lag the internal counters/FSM by exactly one clk.
REQ-027 de SHALL be 1 iff horizontal state H_ACT and vertical state V_ACT.
REQ-028 hsync SHALL equal HS_POL during H_SYN, else ~HS_POL (default: low for h_cnt 656..751).
REQ-029 vsync SHALL equal VS_POL during V_SYN, else ~VS_POL (default: low for v_cnt 490..491, full lines, edges aligned to h_cnt=0).
REQ-030 x and y SHALL present h_cnt and v_cnt zero-extended to 10 bits.
REQ-031 line_start SHALL be 1 iff h_cnt=0; frame_start SHALL be 1 iff h_cnt=0 and v_cnt=0.
REQ-032 With en=0, counters, FSMs and all output registers SHALL hold their values; with en low, line_start/frame_start SHALL be forced to 0.
REQ-033 en rising mid-line SHALL resume counting from the held position, with no skipped or repeated counts.

Reset
REQ-034 rst=1 at a clk edge SHALL set h_cnt=0, v_cnt=0, FSMs to H_ACT/V_ACT, de=0, x=0, y=0, line_start=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-035 rst SHALL take priority over en; reset mid-frame SHALL restart at (0,0) with no partial sync pulse emitted afterwards.
REQ-036 First clk with en=1 after rst release SHALL load outputs for (0,0): de=1, line_start=1, frame_start=1.

Verification
REQ-037 Defaults, rst then en=1 for 2 frames -> frame_start period 420000 clks, line_start period 800 clks, frame_start pulse exactly 1 clk wide.
REQ-038 One line -> de high 640 consecutive clks, hsync low 96 clks starting 656 clks after line_start, x sequence 0..799.
REQ-039 One frame -> de count 307200, vsync low exactly 1600 clks starting at line 490 h=0, y sequence 0..524.
REQ-040 en low for 37 clks at x=300,y=100 -> all outputs frozen, pulses 0; on resume x continues at 301.
REQ-041 rst pulsed 1 clk at x=700,y=491 (vsync asserted) -> next edge vsync/hsync inactive, de=0, x=y=0; next en clk frame_start=1.
REQ-042 HS_POL=1, VS_POL=1 -> hsync/vsync high only inside sync windows, same timing as REQ-038/039.
